// File: rtl/exc_commit_ctrl_if.sv
// Fetch-redirect handshake between the commit controller and the fetch stage.
//   redirect_valid : controller offers a redirect (held until accepted)
//   redirect_pc    : redirect target, stable while redirect_valid is high
//   redirect_ready : fetch accepts the redirect this cycle
// master = commit controller side, slave = fetch side.
interface exc_commit_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller between writeback and the CSR file.
// Picks the highest-priority event of the committing instruction (interrupt,
// ADEF, INE, SYS, BRK, ALE, then ertn), strobes the CSR entry/ertn signals,
// holds the pipeline flush for a drain window and then offers a fetch
// redirect to the exception entry or the ERA.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wb_valid, wb_pc_in, wb_ex_*, wb_ertn : committing instruction and flags
//   csr_crmd_ie, csr_estat_is, csr_ecfg_lie : interrupt state from CSR
//   ex_entry, csr_era : redirect targets from CSR
//   wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush : CSR commit strobes
//   flush, busy       : pipeline kill / commit block
//   rd                : redirect handshake (master side)
module exc_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc_in,
  input  logic        wb_ex_adef,
  input  logic        wb_ex_ine,
  input  logic        wb_ex_sys,
  input  logic        wb_ex_brk,
  input  logic        wb_ex_ale,
  input  logic        wb_ertn,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [31:0] ex_entry,
  input  logic [31:0] csr_era,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        flush,
  output logic        busy,
  exc_commit_ctrl_if.master rd
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_target;
  logic        r_wb_ex;
  logic [5:0]  r_wb_ecode;
  logic [31:0] r_wb_pc;
  logic        r_ertn_flush;
  logic        r_flush;
  logic        r_busy;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic w_int_take;
  logic w_any_exc;
  logic w_event;
  logic w_take;

  // Exception code by priority; ertn-only commits carry no code.
  function automatic logic [5:0] sel_ecode(input logic it, input logic adef,
                                           input logic ine, input logic sys,
                                           input logic brk, input logic ale);
    if (it)        return 6'h00;
    else if (adef) return 6'h08;
    else if (ine)  return 6'h0D;
    else if (sys)  return 6'h0B;
    else if (brk)  return 6'h0C;
    else if (ale)  return 6'h09;
    else           return 6'h00;
  endfunction

  assign w_int_take = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
  assign w_any_exc  = w_int_take | wb_ex_adef | wb_ex_ine | wb_ex_sys
                    | wb_ex_brk | wb_ex_ale;
  assign w_event    = wb_valid & (w_any_exc | wb_ertn);
  // Events are only sampled while idle; everything is ignored while busy.
  assign w_take     = (r_state == IDLE) & w_event;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE:     if (w_event) w_state_nxt = COMMIT;
      COMMIT: begin
        w_state_nxt = DRAIN;
        w_cnt_nxt   = 4'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (r_cnt == 4'd0) w_state_nxt = REDIRECT;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      REDIRECT: if (r_redirect_valid & rd.redirect_ready) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= 4'd0;
      r_wb_ex          <= 1'b0;
      r_wb_ecode       <= 6'd0;
      r_wb_pc          <= 32'd0;
      r_ertn_flush     <= 1'b0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_wb_ex          <= w_take & w_any_exc;
      r_ertn_flush     <= w_take & ~w_any_exc;
      r_flush          <= (w_state_nxt != IDLE);
      r_busy           <= (w_state_nxt != IDLE);
      r_redirect_valid <= (w_state_nxt == REDIRECT);
      if (w_take) begin
        r_wb_ecode <= sel_ecode(w_int_take, wb_ex_adef, wb_ex_ine,
                                wb_ex_sys, wb_ex_brk, wb_ex_ale);
        r_wb_pc    <= wb_pc_in;
      end
      if ((r_state == DRAIN) && (w_state_nxt == REDIRECT))
        r_redirect_pc <= r_target;
    end
  end

  // Redirect target sampled in the same cycle the event is taken.
  always_ff @(posedge clk) begin
    if (w_take) r_target <= w_any_exc ? ex_entry : csr_era;
  end

  assign wb_ex             = r_wb_ex;
  assign wb_ecode          = r_wb_ecode;
  assign wb_esubcode       = 9'd0;
  assign wb_pc             = r_wb_pc;
  assign ertn_flush        = r_ertn_flush;
  assign flush             = r_flush;
  assign busy              = r_busy;
  assign rd.redirect_valid = r_redirect_valid;
  assign rd.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;
  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc_in;
  logic        wb_ex_adef, wb_ex_ine, wb_ex_sys, wb_ex_brk, wb_ex_ale, wb_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_estat_is, csr_ecfg_lie;
  logic [31:0] ex_entry, csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush, flush, busy;

  int checks;
  int failures;

  exc_commit_ctrl_if u_if ();

  exc_commit_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
    .wb_ex_adef(wb_ex_adef), .wb_ex_ine(wb_ex_ine), .wb_ex_sys(wb_ex_sys),
    .wb_ex_brk(wb_ex_brk), .wb_ex_ale(wb_ex_ale), .wb_ertn(wb_ertn),
    .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is),
    .csr_ecfg_lie(csr_ecfg_lie), .ex_entry(ex_entry), .csr_era(csr_era),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .ertn_flush(ertn_flush), .flush(flush), .busy(busy),
    .rd(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_ex_adef = 0; wb_ex_ine = 0; wb_ex_sys = 0;
    wb_ex_brk = 0; wb_ex_ale = 0; wb_ertn = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs(); wb_pc_in = 0; csr_crmd_ie = 0;
    csr_estat_is = 0; csr_ecfg_lie = 0; ex_entry = 32'h1C008000;
    csr_era = 0; u_if.redirect_ready = 0;
    step(); step();
    checks++; if ({wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, flush, busy,
                   u_if.redirect_valid, u_if.redirect_pc} !== '0) begin
      failures++; $display("FAIL reset_outputs got wb_ex=%0b flush=%0b busy=%0b rv=%0b rpc=%h exp all zero",
                           wb_ex, flush, busy, u_if.redirect_valid, u_if.redirect_pc); end
    reset = 0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_syscall();
    wb_valid = 1; wb_ex_sys = 1; wb_pc_in = 32'h1C000100; ex_entry = 32'h1C008000;
    step(); clear_inputs(); ex_entry = 32'hDEAD0000;  // cycle 1
    checks++; if (wb_ex !== 1'b1) begin failures++; $display("FAIL sys_wb_ex got=%0b exp=1", wb_ex); end
    checks++; if (wb_ecode !== 6'h0B) begin failures++; $display("FAIL sys_ecode got=%h exp=0b", wb_ecode); end
    checks++; if (wb_pc !== 32'h1C000100) begin failures++; $display("FAIL sys_wb_pc got=%h exp=1c000100", wb_pc); end
    checks++; if ({ertn_flush, flush, busy, u_if.redirect_valid} !== 4'b0110) begin
      failures++; $display("FAIL sys_c1_ctrl got=%b exp=0110", {ertn_flush, flush, busy, u_if.redirect_valid}); end
    checks++; if (wb_esubcode !== 9'd0) begin failures++; $display("FAIL sys_esubcode got=%h exp=0", wb_esubcode); end
    step();  // cycle 2
    checks++; if ({wb_ex, flush, u_if.redirect_valid} !== 3'b010) begin
      failures++; $display("FAIL sys_c2 got=%b exp=010", {wb_ex, flush, u_if.redirect_valid}); end
    step();  // cycle 3
    checks++; if ({flush, busy, u_if.redirect_valid} !== 3'b110) begin
      failures++; $display("FAIL sys_c3 got=%b exp=110", {flush, busy, u_if.redirect_valid}); end
    step();  // cycle 4
    checks++; if ({flush, u_if.redirect_valid} !== 2'b11) begin
      failures++; $display("FAIL sys_c4_rv got=%b exp=11", {flush, u_if.redirect_valid}); end
    checks++; if (u_if.redirect_pc !== 32'h1C008000) begin
      failures++; $display("FAIL sys_redirect_pc got=%h exp=1c008000", u_if.redirect_pc); end
    u_if.redirect_ready = 1;
    step(); u_if.redirect_ready = 0;  // cycle 5
    checks++; if ({flush, busy, u_if.redirect_valid} !== 3'b000) begin
      failures++; $display("FAIL sys_c5_idle got=%b exp=000", {flush, busy, u_if.redirect_valid}); end
  endtask

  // Runs an already-started event from cycle 1 through redirect acceptance.
  task automatic finish_event();
    step(); step(); step();
    u_if.redirect_ready = 1; step(); u_if.redirect_ready = 0;
  endtask

  task automatic test_priority();
    ex_entry = 32'h1C008000;
    wb_valid = 1; wb_ex_adef = 1; wb_ex_ine = 1; wb_ex_ale = 1; wb_pc_in = 32'h1C000300;
    step(); clear_inputs();
    checks++; if ({wb_ex, wb_ecode} !== {1'b1, 6'h08}) begin
      failures++; $display("FAIL prio_adef got wb_ex=%0b ecode=%h exp 1/08", wb_ex, wb_ecode); end
    finish_event();
    csr_crmd_ie = 1; csr_estat_is = 13'h004; csr_ecfg_lie = 13'h004;
    wb_valid = 1; wb_ex_adef = 1; wb_ex_ine = 1; wb_ex_ale = 1;
    step(); clear_inputs(); csr_crmd_ie = 0; csr_estat_is = 0; csr_ecfg_lie = 0;
    checks++; if ({wb_ex, wb_ecode} !== {1'b1, 6'h00}) begin
      failures++; $display("FAIL prio_int got wb_ex=%0b ecode=%h exp 1/00", wb_ex, wb_ecode); end
    finish_event();
    wb_valid = 1; wb_ex_brk = 1; wb_ex_ale = 1;
    step(); clear_inputs();
    checks++; if (wb_ecode !== 6'h0C) begin failures++; $display("FAIL prio_brk got=%h exp=0c", wb_ecode); end
    finish_event();
  endtask

  task automatic test_ertn();
    ex_entry = 32'h1C008000; csr_era = 32'h1C000200;
    wb_valid = 1; wb_ertn = 1; wb_pc_in = 32'h1C000400;
    step(); clear_inputs(); csr_era = 32'h0;
    checks++; if ({ertn_flush, wb_ex, flush} !== 3'b101) begin
      failures++; $display("FAIL ertn_c1 got=%b exp=101", {ertn_flush, wb_ex, flush}); end
    step();
    checks++; if (ertn_flush !== 1'b0) begin failures++; $display("FAIL ertn_one_cycle got=%0b exp=0", ertn_flush); end
    step(); step();
    checks++; if ({u_if.redirect_valid, u_if.redirect_pc} !== {1'b1, 32'h1C000200}) begin
      failures++; $display("FAIL ertn_redirect got rv=%0b pc=%h exp 1/1c000200", u_if.redirect_valid, u_if.redirect_pc); end
    u_if.redirect_ready = 1; step(); u_if.redirect_ready = 0;
    csr_era = 32'h1C000200;
    wb_valid = 1; wb_ertn = 1; wb_ex_sys = 1; wb_pc_in = 32'h1C000500;
    step(); clear_inputs();
    checks++; if ({wb_ex, ertn_flush, wb_ecode} !== {2'b10, 6'h0B}) begin
      failures++; $display("FAIL ertn_sys got wb_ex=%0b ertn=%0b ecode=%h exp 1/0/0b", wb_ex, ertn_flush, wb_ecode); end
    checks++; if (wb_pc !== 32'h1C000500) begin failures++; $display("FAIL ertn_sys_pc got=%h exp=1c000500", wb_pc); end
    step(); step(); step();
    checks++; if (u_if.redirect_pc !== 32'h1C008000) begin
      failures++; $display("FAIL ertn_sys_target got=%h exp=1c008000", u_if.redirect_pc); end
    u_if.redirect_ready = 1; step(); u_if.redirect_ready = 0;
  endtask

  task automatic test_backpressure();
    ex_entry = 32'h1C00A000;
    wb_valid = 1; wb_ex_sys = 1; wb_pc_in = 32'h1C000600;
    step(); clear_inputs();
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin wb_valid = 1; wb_ex_sys = 1; end
      else clear_inputs();
      checks++; if ({u_if.redirect_valid, flush, busy, wb_ex} !== 4'b1110 || u_if.redirect_pc !== 32'h1C00A000) begin
        failures++; $display("FAIL bp_hold[%0d] got rv/fl/busy/ex=%b pc=%h exp 1110/1c00a000", i,
                             {u_if.redirect_valid, flush, busy, wb_ex}, u_if.redirect_pc); end
      step();
    end
    clear_inputs();
    u_if.redirect_ready = 1; step(); u_if.redirect_ready = 0;
    checks++; if ({u_if.redirect_valid, flush, busy, wb_ex} !== 4'b0000) begin
      failures++; $display("FAIL bp_release got=%b exp=0000", {u_if.redirect_valid, flush, busy, wb_ex}); end
    step();
    checks++; if ({wb_ex, busy} !== 2'b00) begin failures++; $display("FAIL bp_no_second got=%b exp=00", {wb_ex, busy}); end
  endtask

  task automatic test_int_masked();
    csr_crmd_ie = 0; csr_estat_is = 13'h004; csr_ecfg_lie = 13'h004; wb_valid = 1;
    step();
    checks++; if ({wb_ex, busy} !== 2'b00) begin failures++; $display("FAIL int_ie0 got=%b exp=00", {wb_ex, busy}); end
    csr_crmd_ie = 1; csr_ecfg_lie = 13'h008;
    step();
    checks++; if ({wb_ex, busy} !== 2'b00) begin failures++; $display("FAIL int_lie_mask got=%b exp=00", {wb_ex, busy}); end
    csr_ecfg_lie = 13'h004; wb_valid = 0;
    step();
    checks++; if ({wb_ex, busy} !== 2'b00) begin failures++; $display("FAIL int_no_valid got=%b exp=00", {wb_ex, busy}); end
    wb_valid = 1;
    step(); clear_inputs(); csr_crmd_ie = 0; csr_estat_is = 0; csr_ecfg_lie = 0;
    checks++; if ({wb_ex, wb_ecode} !== {1'b1, 6'h00}) begin
      failures++; $display("FAIL int_taken got wb_ex=%0b ecode=%h exp 1/00", wb_ex, wb_ecode); end
    finish_event();
  endtask

  task automatic test_async_reset();
    ex_entry = 32'h1C008000;
    wb_valid = 1; wb_ex_sys = 1; wb_pc_in = 32'h1C000700;
    step(); clear_inputs();
    step();  // in DRAIN
    #2 reset = 1;
    #1;
    checks++; if ({wb_ex, wb_ecode, wb_pc, ertn_flush, flush, busy, u_if.redirect_valid, u_if.redirect_pc} !== '0) begin
      failures++; $display("FAIL async_reset got flush=%0b busy=%0b pc=%h exp all zero", flush, busy, wb_pc); end
    step(); step();
    reset = 0;
    wb_valid = 1; wb_ex_sys = 1; wb_pc_in = 32'h1C000800;
    step(); clear_inputs();
    checks++; if ({wb_ex, wb_ecode, wb_pc} !== {1'b1, 6'h0B, 32'h1C000800}) begin
      failures++; $display("FAIL post_reset_c1 got ex=%0b ecode=%h pc=%h exp 1/0b/1c000800", wb_ex, wb_ecode, wb_pc); end
    step(); step();
    checks++; if (u_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL post_reset_c3 got=%0b exp=0", u_if.redirect_valid); end
    step();
    checks++; if ({u_if.redirect_valid, u_if.redirect_pc} !== {1'b1, 32'h1C008000}) begin
      failures++; $display("FAIL post_reset_c4 got rv=%0b pc=%h exp 1/1c008000", u_if.redirect_valid, u_if.redirect_pc); end
    u_if.redirect_ready = 1; step(); u_if.redirect_ready = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b exp=0", busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_syscall();
    test_priority();
    test_ertn();
    test_backpressure();
    test_int_masked();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
